my_div: RTL and testbench
=========================

# my_div

Iterative 32-bit integer divider that pairs with the `my_mul` combinational multiplier in the lab arithmetic set. It takes a dividend and a divisor and returns the quotient, the remainder and an exception flag. It uses a restoring algorithm that computes one quotient bit per clock, with a start/done handshake. Results stay stable until the next accepted start.

## Interface
- `BITWIDTH`, 32, operand/result width (≥2)
- `clk` in 1: rising-edge clock
- `rstn` in 1: asynchronous, active-low reset
- `start` in 1: request; sampled only in IDLE
- `ain` in BITWIDTH: dividend, sampled with `start`
- `bin` in BITWIDTH: divisor, sampled with `start`
- `dout` out BITWIDTH: quotient
- `rem` out BITWIDTH: remainder
- `overflow` out 1: divide-by-zero, or signed overflow (signed build only)
- `busy` out 1: high from the accepting edge until the edge that leaves DONE
- `done` out 1: one-cycle pulse; the result is valid from this cycle onward

## Operation
- States: IDLE, CALC, FIX (signed build only), DONE.
- IDLE → CALC on `start`=1 with `bin`≠0.
  - Latch the operands (absolute values in the signed build).
  - Clear the partial remainder.
  - Set the bit counter to BITWIDTH-1.
- IDLE → DONE on `start`=1 with `bin`=0:
  - `dout` = all ones.
  - `rem` = `ain`.
  - `overflow` = 1.
- CALC, each cycle:
  - Form trial = {R[BITWIDTH-2:0], Q[MSB]} − D.
  - If there is no borrow, R ← trial and shift 1 into Q.
  - Otherwise R ← the shifted value and shift 0 into Q.
  - Decrement the counter.
  - At counter 0, go to DONE (unsigned) or FIX (signed).
- FIX:
  - Negate Q if the operand signs differ.
  - Negate R if the dividend is negative.
  - Result truncates toward zero.
  - Go to DONE.
- DONE: register `dout`/`rem`/`overflow`, assert `done`, then go to IDLE.
- `overflow` = 0 for every normal division.
- `start` while `busy`=1 is ignored. It is not queued.
- Outputs hold their last result through IDLE.
- Internal arithmetic uses width BITWIDTH+1 for the trial subtract. The borrow is bit BITWIDTH.

## Timing
- Reset (async assert, sync release):
  - State = IDLE.
  - `dout`, `rem`, `overflow`, `busy`, `done` = 0.
  - Counter and datapath registers = 0.
- Reset asserted mid-operation aborts immediately. No `done` is produced.
- Start accepted at edge E, unsigned:
  - CALC spans edges E+1 … E+BITWIDTH.
  - `done`=1 in the cycle following edge E+BITWIDTH+1.
  - Latency is BITWIDTH+1 edges (33 at default).
- Signed build: one extra edge (34 at default).
- Divide-by-zero: `done` in the cycle after edge E+1, a latency of 1.
- `busy` falls on the same edge that `done` falls.
- `start` held high during the `done` cycle is accepted on the next edge, because the FSM is then in IDLE. Back-to-back throughput is therefore one operation per latency+1 cycles.

## Configuration
- `MY_DIV_SIGNED_EN` defined:
  - Operands and results are two's complement.
  - The FIX state is present.
  - most-negative ÷ −1 sets `overflow`=1, `dout`=most-negative, `rem`=0.
- Not defined:
  - Unsigned operation only.
  - FIX state, sign logic and signed-overflow detection are absent.
  - `overflow` means divide-by-zero only.

## Structure
- `my_div_pkg` holds:
  - the state enum (IDLE/CALC/FIX/DONE);
  - the default BITWIDTH constant;
  - the counter-width constant $clog2(BITWIDTH).
- The sub-module `my_div_step` is a combinational single restoring step. It takes R, the incoming bit and D, and produces the new R and the quotient bit. It is instantiated once inside `my_div`.

## Test plan
- 100 ÷ 7 (unsigned): start pulse → after 33 edges `done`=1, `dout`=14, `rem`=2, `overflow`=0, `busy` low on the next edge.
- 0xFFFFFFFF ÷ 1 and 0xBFFFFFFF ÷ 0xFFFFFFFF → `dout`=0xFFFFFFFF/`rem`=0 and `dout`=0/`rem`=0xBFFFFFFF.
- 5 ÷ 0 → `done` 1 edge after acceptance, `dout`=0xFFFFFFFF, `rem`=5, `overflow`=1.
- `start` pulsed with new operands at edge 10 of a running 100 ÷ 7 → ignored; the result is still 14 r 2.
- `rstn` dropped at edge 15 of a run → all outputs 0 immediately. After release, IDLE with no `done`. A new 9 ÷ 3 then gives 3 r 0.
- With `MY_DIV_SIGNED_EN`:
  - −7 ÷ 2 → `dout`=−3, `rem`=−1, after 34 edges.
  - 0x80000000 ÷ −1 → `overflow`=1, `dout`=0x80000000, `rem`=0.

Source files
------------

// File: rtl/my_div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package my_div_pkg;

   localparam int unsigned DEFAULT_BITWIDTH = 32;
   localparam int unsigned DEFAULT_CNT_W    = $clog2(DEFAULT_BITWIDTH);

   typedef enum logic [1:0] {
      StIdle,
      StCalc,
      StFix,
      StDone
   } state_e;

endpackage

// File: rtl/my_div_step.sv
// One combinational restoring-division step: shift in a bit, trial-subtract the divisor.
module my_div_step
   import my_div_pkg::*;
#(
   parameter int unsigned BITWIDTH = DEFAULT_BITWIDTH
) (
   // The partial remainder's MSB is always zero before a step, so only the low bits are taken
   input  logic [BITWIDTH-2:0] r,
   input  logic                bit_in,
   input  logic [BITWIDTH-1:0] d,
   output logic [BITWIDTH-1:0] r_next,
   output logic                q_bit
);

   logic [BITWIDTH-1:0] shifted;
   logic [BITWIDTH:0]   trial;

   assign shifted = {r, bit_in};
   assign trial   = {1'b0, shifted} - {1'b0, d};
   assign q_bit   = ~trial[BITWIDTH];
   assign r_next  = q_bit ? trial[BITWIDTH-1:0] : shifted;

endmodule

// File: rtl/my_div.sv
// Iterative restoring divider, one quotient bit per clock with start/done handshake.
// Define MY_DIV_SIGNED_EN for two's-complement operation (adds the FIX state).
module my_div
   import my_div_pkg::*;
#(
   parameter int unsigned BITWIDTH = DEFAULT_BITWIDTH
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                start,
   input  logic [BITWIDTH-1:0] ain,
   input  logic [BITWIDTH-1:0] bin,
   output logic [BITWIDTH-1:0] dout,
   output logic [BITWIDTH-1:0] rem,
   output logic                overflow,
   output logic                busy,
   output logic                done
);

   localparam int unsigned CW = $clog2(BITWIDTH);

   state_e              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [BITWIDTH-1:0] q_q, q_d, r_q, r_d, d_q, d_d;
   logic [BITWIDTH-1:0] dout_q, dout_d, rem_q, rem_d;
   logic                ovf_q, ovf_d, overflow_q, overflow_d;
   logic                busy_q, busy_d, done_q, done_d;

   logic [BITWIDTH-1:0] a_op, b_op, r_step;
   logic                q_bit, min_ovf;

`ifdef MY_DIV_SIGNED_EN
   logic qneg_q, qneg_d, rneg_q, rneg_d;

   assign a_op    = ain[BITWIDTH-1] ? -ain : ain;
   assign b_op    = bin[BITWIDTH-1] ? -bin : bin;
   assign min_ovf = (ain == {1'b1, {(BITWIDTH-1){1'b0}}}) && (bin == '1);
`else
   assign a_op    = ain;
   assign b_op    = bin;
   assign min_ovf = 1'b0;
`endif

   my_div_step #(
      .BITWIDTH (BITWIDTH)
   ) u_step (
      .r      (r_q[BITWIDTH-2:0]),
      .bit_in (q_q[BITWIDTH-1]),
      .d      (d_q),
      .r_next (r_step),
      .q_bit  (q_bit)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      q_d        = q_q;
      r_d        = r_q;
      d_d        = d_q;
      ovf_d      = ovf_q;
      dout_d     = dout_q;
      rem_d      = rem_q;
      overflow_d = overflow_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
`ifdef MY_DIV_SIGNED_EN
      qneg_d     = qneg_q;
      rneg_d     = rneg_q;
`endif
      // busy drops together with done; a start accepted on that edge re-raises it below
      if (done_q) begin
         busy_d = 1'b0;
      end

      unique case (state_q)
         StIdle: begin
            if (start) begin
               busy_d = 1'b1;
               if (bin == '0) begin
                  q_d     = '1;
                  r_d     = ain;
                  ovf_d   = 1'b1;
                  state_d = StDone;
               end else begin
                  q_d     = a_op;
                  d_d     = b_op;
                  r_d     = '0;
                  cnt_d   = CW'(BITWIDTH - 1);
                  ovf_d   = min_ovf;
                  state_d = StCalc;
`ifdef MY_DIV_SIGNED_EN
                  qneg_d  = ain[BITWIDTH-1] ^ bin[BITWIDTH-1];
                  rneg_d  = ain[BITWIDTH-1];
`endif
               end
            end
         end
         StCalc: begin
            q_d   = {q_q[BITWIDTH-2:0], q_bit};
            r_d   = r_step;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0) begin
`ifdef MY_DIV_SIGNED_EN
               state_d = StFix;
`else
               state_d = StDone;
`endif
            end
         end
`ifdef MY_DIV_SIGNED_EN
         StFix: begin
            if (qneg_q) q_d = -q_q;
            if (rneg_q) r_d = -r_q;
            state_d = StDone;
         end
`endif
         StDone: begin
            dout_d     = q_q;
            rem_d      = r_q;
            overflow_d = ovf_q;
            done_d     = 1'b1;
            state_d    = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         q_q        <= '0;
         r_q        <= '0;
         d_q        <= '0;
         ovf_q      <= 1'b0;
         dout_q     <= '0;
         rem_q      <= '0;
         overflow_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef MY_DIV_SIGNED_EN
         qneg_q     <= 1'b0;
         rneg_q     <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         q_q        <= q_d;
         r_q        <= r_d;
         d_q        <= d_d;
         ovf_q      <= ovf_d;
         dout_q     <= dout_d;
         rem_q      <= rem_d;
         overflow_q <= overflow_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
`ifdef MY_DIV_SIGNED_EN
         qneg_q     <= qneg_d;
         rneg_q     <= rneg_d;
`endif
      end
   end

   assign dout     = dout_q;
   assign rem      = rem_q;
   assign overflow = overflow_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_my_div.sv
// Scoreboard bench for my_div: stimulus pushes expected results, a monitor checks each done.
module tb_my_div;

   localparam int W = 32;
`ifdef MY_DIV_SIGNED_EN
   localparam int LAT = 34;
`else
   localparam int LAT = 33;
`endif

   logic         clk   = 1'b0;
   logic         rstn  = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] ain   = '0;
   logic [W-1:0] bin   = '0;
   logic [W-1:0] dout, rem;
   logic         overflow, busy, done;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         ov;
      int           cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   my_div #(
      .BITWIDTH (W)
   ) dut (
      .clk      (clk),
      .rstn     (rstn),
      .start    (start),
      .ain      (ain),
      .bin      (bin),
      .dout     (dout),
      .rem      (rem),
      .overflow (overflow),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest expected result
   always @(negedge clk) begin
      if (done) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 required done=0 (cycle %0d)", cyc);
         end else begin
            mon_e = sb.pop_front();
            chk("dout", dout, mon_e.q);
            chk("rem", rem, mon_e.r);
            chk("overflow", W'(overflow), W'(mon_e.ov));
            chk("done_cycle", W'(cyc), W'(mon_e.cyc));
            chk("busy_in_done", W'(busy), W'(1));
         end
      end
   end

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] q,
                        input logic [W-1:0] r, input logic ov, input int lat);
      @(negedge clk);
      ain   = a;
      bin   = b;
      start = 1'b1;
      sb.push_back('{q: q, r: r, ov: ov, cyc: cyc + 1 + lat});
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string nm, input bit idle_after);
      bit seen = 1'b0;
      for (int i = 0; i < 80; i++) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got no done required done within 80 cycles", nm);
      end else begin
         @(negedge clk);
         chk({nm, "_done_pulse"}, W'(done), W'(0));
         if (idle_after) chk({nm, "_busy_after"}, W'(busy), W'(0));
      end
   endtask

   task automatic run(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] q, input logic [W-1:0] r, input logic ov,
                      input int lat);
      issue(a, b, q, r, ov, lat);
      wait_done(nm, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish required finish by 200000ns");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int e1;
      #2 rstn = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_dout", dout, '0);
      chk("rst_rem", rem, '0);
      chk("rst_overflow", W'(overflow), W'(0));
      chk("rst_busy", W'(busy), W'(0));
      chk("rst_done", W'(done), W'(0));
      rstn = 1'b1;

      run("d100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, LAT);
      run("d5_0", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1);
      run("d9_3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, LAT);
      run("d12345678", 32'd12345678, 32'd1000, 32'd12345, 32'd678, 1'b0, LAT);
      run("d0_5", 32'd0, 32'd5, 32'd0, 32'd0, 1'b0, LAT);
`ifdef MY_DIV_SIGNED_EN
      run("sm7_2", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, LAT);
      run("s7_m2", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, LAT);
      run("sm7_m2", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b0, LAT);
      run("smin_m1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b1, LAT);
      run("sm1_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, LAT);
`else
      run("uffff_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, LAT);
      run("ubfff_ffff", 32'hBFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'hBFFF_FFFF, 1'b0, LAT);
      run("uffff_8001", 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE, 1'b0, LAT);
`endif

      // start pulsed mid-run with new operands is ignored
      issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, LAT);
      repeat (9) @(negedge clk);
      ain   = 32'd50;
      bin   = 32'd5;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("ignore", 1'b1);

      // start held high through done is accepted on the following edge
      @(negedge clk);
      ain   = 32'd200;
      bin   = 32'd10;
      start = 1'b1;
      e1    = cyc + 1;
      sb.push_back('{q: 32'd20, r: 32'd0, ov: 1'b0, cyc: e1 + LAT});
      sb.push_back('{q: 32'd20, r: 32'd1, ov: 1'b0, cyc: e1 + 2 * LAT + 1});
      @(negedge clk);
      ain = 32'd201;
      wait_done("b2b_first", 1'b0);
      start = 1'b0;
      chk("b2b_busy_held", W'(busy), W'(1));
      wait_done("b2b_second", 1'b1);

      // reset mid-operation aborts with no done
      @(negedge clk);
      ain   = 32'd100;
      bin   = 32'd7;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (15) @(posedge clk);
      #1 rstn = 1'b0;
      #1;
      chk("abort_dout", dout, '0);
      chk("abort_rem", rem, '0);
      chk("abort_overflow", W'(overflow), W'(0));
      chk("abort_busy", W'(busy), W'(0));
      chk("abort_done", W'(done), W'(0));
      @(negedge clk);
      rstn = 1'b1;
      repeat (40) @(negedge clk);
      chk("abort_idle_busy", W'(busy), W'(0));
      run("after_abort_9_3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, LAT);

      chk("queue_empty", W'(sb.size()), W'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
